mvm_sched_ctrl: RTL and testbench
=================================

Name: mvm_sched_ctrl

Overview:
- Sequencer for the 8-MAC systolic matrix-vector datapath: one B-vector FIFO and NUM_MACS A-row FIFOs feed a MAC chain, and B/En propagate one MAC per cycle.
- Starts once all input FIFOs are full and clears the accumulators.
- Issues skewed FIFO read requests so each A element meets its B element at the right MAC.
- Waits for the pipeline to drain, then hands results out one MAC at a time over a valid/ready port.

Parameters:
- NUM_MACS, 8: MACs in the chain; also the number of A FIFOs.
- VEC_LEN, 8: elements per vector (FIFO depth consumed per run).
- FIFO_RD_LAT, 1: cycles from rdreq to q valid.
- MAC_LAT, 1: cycles from En to an updated Cout.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  run request pulse
- a_full  in  NUM_MACS  wrfull of each A FIFO
- b_full  in  1  wrfull of B FIFO
- rd_a  out  NUM_MACS  rdreq to A FIFO i
- rd_b  out  1  rdreq to B FIFO
- mac_clr  out  1  accumulator clear, all MACs
- mac_en  out  1  En into MAC0 (chain propagates it)
- busy  out  1  high in any state except IDLE
- start_err  out  1  1-cycle pulse: start rejected
- res_idx  out  $clog2(NUM_MACS)  MAC index whose Cout is presented
- res_valid  out  1  res_idx is valid
- res_ready  in  1  consumer accepts the current result
- done  out  1  1-cycle pulse after the last result is accepted
- perf_cycles  out  32  busy-cycle count (see optional feature)

Behaviour:
- Reset values: state IDLE; all outputs 0; step counter t=0; res_idx=0.
- Reset is async and may arrive mid-run: return to IDLE immediately, outputs 0. The FIFOs are reset by the same rst_n externally.
- States: IDLE, CLEAR, STREAM, UNLOAD, DONE.
- IDLE:
  - start=1 with &a_full & b_full → CLEAR.
  - start=1 with any FIFO not full → start_err=1 for one cycle, stay IDLE.
- CLEAR: mac_clr=1 for exactly one cycle; t←0; → STREAM.
- STREAM: step counter t increments every cycle from 0. Outputs are decoded combinationally from the registered state and t, with no stalls.
  - rd_b=1 for t ∈ [0, VEC_LEN-1].
  - rd_a[i]=1 for t ∈ [i, i+VEC_LEN-1].
  - mac_en=1 for t ∈ [FIFO_RD_LAT, FIFO_RD_LAT+VEC_LEN-1].
  - T_LAST = VEC_LEN+NUM_MACS-2+FIFO_RD_LAT+MAC_LAT. At t==T_LAST → UNLOAD, and t resets to 0.
  - Defaults give T_LAST=16, so STREAM lasts 17 cycles.
- Read counts per run: exactly VEC_LEN rdreqs per FIFO. rd_a[i] and rd_b are never asserted outside STREAM.
- UNLOAD: res_valid=1 with res_idx starting at 0.
  - Transfer occurs when res_valid & res_ready; then res_idx increments.
  - Transfer at res_idx==NUM_MACS-1 → DONE.
  - res_ready=0 holds res_idx and res_valid indefinitely.
- DONE: done=1 for one cycle; → IDLE, res_idx←0, res_valid←0.
- start while busy is ignored: no error, no restart.
- Counter widths: t is $clog2(T_LAST+1) bits and never wraps, because the state exits at T_LAST. res_idx has no wrap past NUM_MACS-1.
- start_err and done never assert in the same cycle.

Optional Feature:
- Macro: MVM_SCHED_PERF_CNT_EN.
- Defined:
  - perf_cycles clears to 0 on the IDLE→CLEAR transition.
  - Increments each cycle busy=1, saturating at 32'hFFFF_FFFF.
  - Holds its value in IDLE until the next accepted start; reset value 0.
- Undefined: perf_cycles tied to 0, no counter logic.

Test Plan:
- Nominal run, defaults, all full, res_ready tied 1; start at cycle 0:
  - mac_clr at cycle 1.
  - rd_b cycles 2–9; rd_a[7] cycles 9–16; mac_en cycles 3–10.
  - res_valid cycles 19–26 with res_idx 0..7.
  - done at cycle 27.
  - perf_cycles=27 when the macro is defined.
- start with a_full=8'hFE → start_err=1 for one cycle; busy stays 0; no rd_*/mac_clr asserted.
- Backpressure: res_ready=0 for 5 cycles at res_idx=3 → res_idx holds 3 and res_valid stays 1; then 4..7 are transferred and done pulses.
- start re-pulsed during STREAM t=5 → no effect; rd_* counts still 8 each; single done.
- rst_n low at STREAM t=4 → all outputs 0 same cycle. After release with FIFOs refilled, a fresh start completes a full nominal run.
- Read-count check: count rd_a[i] and rd_b highs per run → exactly 8 each, and rd_a[i] first asserts exactly i cycles after rd_b.

Source files
------------

// File: rtl/mvm_sched_ctrl.sv
// -----------------------------------------------------------------------------
// mvm_sched_ctrl
//
// Sequencer for an 8-MAC systolic matrix-vector datapath. One B-vector FIFO and
// NUM_MACS A-row FIFOs feed a MAC chain along which B and En advance one MAC
// per cycle. A run starts once every input FIFO is full. The sequencer clears
// the accumulators, issues skewed read requests so that each A element meets
// its B element at the correct MAC, and waits for the pipeline to drain. It
// then presents the results one MAC index at a time over a valid/ready port.
//
// Optional feature (compile-time macro MVM_SCHED_PERF_CNT_EN):
//   defined   - perf_cycles counts busy cycles for the current or most recent
//               run. It saturates at 32'hFFFF_FFFF and clears when a start is
//               accepted.
//   undefined - perf_cycles is tied to 0.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   start        run request pulse
//   a_full       wrfull of each A FIFO
//   b_full       wrfull of the B FIFO
//   rd_a         rdreq to each A FIFO
//   rd_b         rdreq to the B FIFO
//   mac_clr      accumulator clear, all MACs
//   mac_en       En into MAC0 (the chain propagates it)
//   busy         high in every state except IDLE
//   start_err    1-cycle pulse: start rejected because a FIFO was not full
//   res_idx      MAC index whose Cout is presented
//   res_valid    res_idx is valid
//   res_ready    consumer accepts the current result
//   done         1-cycle pulse after the last result is accepted
//   perf_cycles  busy-cycle count (0 unless MVM_SCHED_PERF_CNT_EN)
// -----------------------------------------------------------------------------
module mvm_sched_ctrl #(
  parameter int NUM_MACS    = 8,
  parameter int VEC_LEN     = 8,
  parameter int FIFO_RD_LAT = 1,
  parameter int MAC_LAT     = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [NUM_MACS-1:0]         a_full,
  input  logic                        b_full,
  output logic [NUM_MACS-1:0]         rd_a,
  output logic                        rd_b,
  output logic                        mac_clr,
  output logic                        mac_en,
  output logic                        busy,
  output logic                        start_err,
  output logic [$clog2(NUM_MACS)-1:0] res_idx,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic                        done,
  output logic [31:0]                 perf_cycles
);

  // The last STREAM step. The final A element (FIFO NUM_MACS-1) is read at step
  // VEC_LEN+NUM_MACS-2. It emerges FIFO_RD_LAT cycles later and lands in Cout
  // after another MAC_LAT cycles.
  localparam int T_LAST = VEC_LEN + NUM_MACS - 2 + FIFO_RD_LAT + MAC_LAT;
  localparam int T_W    = $clog2(T_LAST + 1);
  localparam int IDX_W  = $clog2(NUM_MACS);

  localparam logic [T_W-1:0]   T_LAST_T = T_W'(T_LAST);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MACS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_UNLOAD,
    S_DONE
  } state_t;

  state_t         state;
  logic [T_W-1:0] t;
  logic           all_full;
  logic           accept;

  assign all_full = (&a_full) & b_full;
  assign accept   = (state == S_IDLE) & start & all_full;

  // ---------------------------------------------------------------------------
  // Control FSM. The step counter t, the result index and the start_err pulse
  // are all registered here. A start request is examined only in IDLE, so a
  // start that arrives during a run is ignored.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments so that every
  // register samples values from before the edge, independent of the order of
  // the statements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      t         <= '0;
      res_idx   <= '0;
      start_err <= 1'b0;
    end else begin
      start_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (all_full) state     <= S_CLEAR;
            else          start_err <= 1'b1;
          end
        end
        S_CLEAR: begin
          t     <= '0;
          state <= S_STREAM;
        end
        S_STREAM: begin
          // t never wraps: the state exits as soon as t reaches T_LAST.
          if (t == T_LAST_T) begin
            t     <= '0;
            state <= S_UNLOAD;
          end else begin
            t <= t + 1'b1;
          end
        end
        S_UNLOAD: begin
          // res_valid is high for the whole of this state, so a transfer
          // happens exactly when res_ready is high. res_idx stays at its
          // last value on the final transfer and does not wrap.
          if (res_ready) begin
            if (res_idx == IDX_LAST) state   <= S_DONE;
            else                     res_idx <= res_idx + 1'b1;
          end
        end
        S_DONE: begin
          res_idx <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs are decoded directly from the registered state. An
  // asynchronous reset therefore drives them to 0 in the same cycle.
  // ---------------------------------------------------------------------------
  assign busy      = (state != S_IDLE);
  assign mac_clr   = (state == S_CLEAR);
  assign res_valid = (state == S_UNLOAD);
  assign done      = (state == S_DONE);

  // ---------------------------------------------------------------------------
  // STREAM read-request and enable windows, decoded from t:
  //   rd_b      : t in [0, VEC_LEN-1]
  //   rd_a[i]   : t in [i, i+VEC_LEN-1]   (one-cycle skew per MAC)
  //   mac_en    : t in [FIFO_RD_LAT, FIFO_RD_LAT+VEC_LEN-1]
  // Each window is VEC_LEN steps wide, so each FIFO gets exactly VEC_LEN reads.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this always_comb block is given a default before any
  // condition is tested, so that no path leaves a value unassigned and infers
  // a latch.
  always_comb begin
    int tv;
    tv     = int'(t);
    rd_a   = '0;
    rd_b   = 1'b0;
    mac_en = 1'b0;
    if (state == S_STREAM) begin
      rd_b   = (tv < VEC_LEN);
      mac_en = (tv >= FIFO_RD_LAT) && (tv < FIFO_RD_LAT + VEC_LEN);
      for (int i = 0; i < NUM_MACS; i++) begin
        rd_a[i] = (tv >= i) && (tv < i + VEC_LEN);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional busy-cycle counter.
  // ---------------------------------------------------------------------------
`ifdef MVM_SCHED_PERF_CNT_EN
  logic [31:0] perf_q;

  // The counter clears when a start is accepted. It counts while busy and
  // keeps its value through IDLE so that it can be read after the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (accept) begin
      perf_q <= '0;
    end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_mvm_sched_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mvm_sched_ctrl
//
// Self-checking bench for mvm_sched_ctrl with the default parameters.
//   - Start-rejection vectors from a small {inputs, expected} table.
//   - Cycle-by-cycle scenarios (nominal run, backpressure, start re-pulse,
//     random traffic) compared against a timeline model. For each accepted
//     start, the model lays out the expected waveform from the window
//     arithmetic for the run.
//   - A hand-written asynchronous reset in the middle of STREAM.
// Outputs are sampled on the falling edge and inputs are driven right after
// sampling, so nothing changes near the rising edge.
// -----------------------------------------------------------------------------
module tb_mvm_sched_ctrl;

  localparam int N      = 8;
  localparam int V      = 8;
  localparam int FRL    = 1;
  localparam int ML     = 1;
  localparam int T_LAST = V + N - 2 + FRL + ML;
  localparam int IW     = $clog2(N);
  localparam int MAXC   = 2048;
  localparam int ASZ    = MAXC + 64;

`ifdef MVM_SCHED_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  a_full;
  logic          b_full;
  logic [N-1:0]  rd_a;
  logic          rd_b;
  logic          mac_clr;
  logic          mac_en;
  logic          busy;
  logic          start_err;
  logic [IW-1:0] res_idx;
  logic          res_valid;
  logic          res_ready;
  logic          done;
  logic [31:0]   perf_cycles;

  mvm_sched_ctrl #(
    .NUM_MACS   (N),
    .VEC_LEN    (V),
    .FIFO_RD_LAT(FRL),
    .MAC_LAT    (ML)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a_full     (a_full),
    .b_full     (b_full),
    .rd_a       (rd_a),
    .rd_b       (rd_b),
    .mac_clr    (mac_clr),
    .mac_en     (mac_en),
    .busy       (busy),
    .start_err  (start_err),
    .res_idx    (res_idx),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .done       (done),
    .perf_cycles(perf_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [N-1:0]  rd_a;
    logic          rd_b;
    logic          mac_clr;
    logic          mac_en;
    logic          busy;
    logic          start_err;
    logic          res_valid;
    logic [IW-1:0] res_idx;
    logic          done;
  } outs_t;

  function automatic outs_t sample_outs();
    outs_t o;
    o.rd_a      = rd_a;
    o.rd_b      = rd_b;
    o.mac_clr   = mac_clr;
    o.mac_en    = mac_en;
    o.busy      = busy;
    o.start_err = start_err;
    o.res_valid = res_valid;
    o.res_idx   = res_idx;
    o.done      = done;
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // Scenario stimulus and timeline model
  // ---------------------------------------------------------------------------
  logic         s_start [ASZ];
  logic [N-1:0] s_afull [ASZ];
  logic         s_bfull [ASZ];
  logic         s_ready [ASZ];
  outs_t        e_out   [ASZ];
  logic [31:0]  e_perf  [ASZ];
  int           e_runs;
  logic [31:0]  perf_model;
  int           first_valid_c;
  int           done_c;

  task automatic clear_stim();
    for (int c = 0; c < ASZ; c++) begin
      s_start[c] = 1'b0;
      s_afull[c] = '1;
      s_bfull[c] = 1'b1;
      s_ready[c] = 1'b1;
    end
  endtask

  // Lays out the expected outputs for cycles 0..len-1. Cycle 0 is the first
  // cycle of the scenario, and the DUT is assumed to be idle at that point.
  task automatic build_model(input int len);
    int c;
    int s;
    int cc;
    int idx;
    int d;
    e_runs = 0;
    for (int x = 0; x < ASZ; x++) begin
      e_out[x]  = '0;
      e_perf[x] = perf_model;
    end
    c = 0;
    while (c < len) begin
      if (s_start[c] && (&s_afull[c]) && s_bfull[c]) begin
        s = c;
        e_runs++;
        e_out[s + 1].mac_clr = 1'b1;
        for (int k = 0; k <= T_LAST; k++) begin
          cc = s + 2 + k;
          e_out[cc].rd_b   = (k < V);
          e_out[cc].mac_en = (k >= FRL) && (k < FRL + V);
          for (int i = 0; i < N; i++) e_out[cc].rd_a[i] = (k >= i) && (k < i + V);
        end
        cc  = s + 3 + T_LAST;
        idx = 0;
        while (idx < N && cc < ASZ - 1) begin
          e_out[cc].res_valid = 1'b1;
          e_out[cc].res_idx   = IW'(idx);
          if (s_ready[cc]) idx++;
          cc++;
        end
        d = cc;
        e_out[d].done    = 1'b1;
        e_out[d].res_idx = IW'(N - 1);
        for (int x = s + 1; x <= d; x++) e_out[x].busy = 1'b1;
        for (int x = s + 1; x < ASZ; x++)
          e_perf[x] = (x <= d + 1) ? 32'(x - s - 1) : 32'(d - s);
        c = d + 1;
      end else begin
        if (s_start[c]) e_out[c + 1].start_err = 1'b1;
        c++;
      end
    end
  endtask

  task automatic run_scenario(input string tag, input int len);
    outs_t        act;
    outs_t        prev;
    int           cnt_rdb;
    int           cnt_done;
    int           cnt_rda [N];
    int           last_rdb_rise;
    logic [31:0]  exp_perf;
    build_model(len);
    cnt_rdb       = 0;
    cnt_done      = 0;
    last_rdb_rise = -1;
    first_valid_c = -1;
    done_c        = -1;
    prev          = '0;
    for (int i = 0; i < N; i++) cnt_rda[i] = 0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      act = sample_outs();
      check($sformatf("%s outs c%0d", tag, c), 64'(act), 64'(e_out[c]));
      exp_perf = PERF_ON ? e_perf[c] : 32'd0;
      check($sformatf("%s perf c%0d", tag, c), 64'(perf_cycles), 64'(exp_perf));
      if (act.rd_b) cnt_rdb++;
      if (act.done) cnt_done++;
      if (act.rd_b && !prev.rd_b) last_rdb_rise = c;
      for (int i = 0; i < N; i++) begin
        if (act.rd_a[i]) cnt_rda[i]++;
        if (act.rd_a[i] && !prev.rd_a[i] && last_rdb_rise >= 0)
          check($sformatf("%s rd_a%0d skew c%0d", tag, i, c), 64'(c - last_rdb_rise), 64'(i));
      end
      if (act.res_valid && first_valid_c < 0) first_valid_c = c;
      if (act.done && done_c < 0) done_c = c;
      prev = act;
      start     = s_start[c];
      a_full    = s_afull[c];
      b_full    = s_bfull[c];
      res_ready = s_ready[c];
    end
    start = 1'b0;
    check($sformatf("%s rd_b count", tag), 64'(cnt_rdb), 64'(V * e_runs));
    for (int i = 0; i < N; i++)
      check($sformatf("%s rd_a%0d count", tag, i), 64'(cnt_rda[i]), 64'(V * e_runs));
    check($sformatf("%s done count", tag), 64'(cnt_done), 64'(e_runs));
    perf_model = e_perf[len - 1];
  endtask

  // ---------------------------------------------------------------------------
  // Start-rejection vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         start;
    logic [N-1:0] af;
    logic         bf;
    logic         exp_err;
    logic         exp_busy;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    outs_t o;
    vecs[0] = '{1'b1, 8'hFE, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'hEF, 1'b0, 1'b1, 1'b0};

    rst_n     = 1'b0;
    start     = 1'b0;
    a_full    = '0;
    b_full    = 1'b0;
    res_ready = 1'b1;
    perf_model = 32'd0;

    // Reset state.
    #12;
    o = sample_outs();
    check("reset outs", 64'(o), 64'(0));
    check("reset perf", 64'(perf_cycles), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Start rejection: start_err is a single pulse, and no run starts.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start  = vecs[k].start;
      a_full = vecs[k].af;
      b_full = vecs[k].bf;
      @(negedge clk);
      start = 1'b0;
      check($sformatf("vec%0d start_err", k), 64'(start_err), 64'(vecs[k].exp_err));
      check($sformatf("vec%0d busy", k), 64'(busy), 64'(vecs[k].exp_busy));
      check($sformatf("vec%0d no reads", k), 64'({rd_a, rd_b, mac_clr, mac_en}), 64'(0));
      @(negedge clk);
      check($sformatf("vec%0d err pulse end", k), 64'({start_err, busy}), 64'(0));
    end

    // Nominal run.
    clear_stim();
    s_start[0] = 1'b1;
    run_scenario("nominal", 40);
    check("nominal first res_valid cycle", 64'(first_valid_c), 64'(19));
    check("nominal done cycle", 64'(done_c), 64'(27));
    check("nominal perf", 64'(perf_cycles), PERF_ON ? 64'(27) : 64'(0));

    // Backpressure at res_idx 3 for 5 cycles.
    clear_stim();
    s_start[0] = 1'b1;
    for (int c = 22; c < 27; c++) s_ready[c] = 1'b0;
    run_scenario("backpressure", 45);
    check("backpressure done cycle", 64'(done_c), 64'(32));

    // Start re-pulsed at STREAM t=5 is ignored.
    clear_stim();
    s_start[0] = 1'b1;
    s_start[7] = 1'b1;
    run_scenario("restart", 40);
    check("restart done cycle", 64'(done_c), 64'(27));

    // Random traffic.
    clear_stim();
    for (int c = 0; c < 1300; c++) begin
      s_start[c] = ($urandom_range(0, 15) == 0);
      s_afull[c] = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      s_bfull[c] = ($urandom_range(0, 7) != 0);
      s_ready[c] = ($urandom_range(0, 3) != 0);
    end
    run_scenario("random", 1500);

    // Asynchronous reset at STREAM t=4.
    @(negedge clk);
    a_full    = '1;
    b_full    = 1'b1;
    res_ready = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid-run rd_b before reset", 64'({rd_b, rd_a[4], rd_a[5]}), 64'(3'b110));
    #2;
    rst_n = 1'b0;
    #1;
    o = sample_outs();
    check("mid-run reset outs", 64'(o), 64'(0));
    check("mid-run reset perf", 64'(perf_cycles), 64'(0));
    @(negedge clk);
    rst_n      = 1'b1;
    perf_model = 32'd0;

    // A fresh run after the FIFOs have been refilled.
    clear_stim();
    s_start[0] = 1'b1;
    run_scenario("post_reset", 40);
    check("post_reset done cycle", 64'(done_c), 64'(27));
    check("post_reset perf", 64'(perf_cycles), PERF_ON ? 64'(27) : 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
